// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry derivation, refill FSM encoding and address field helpers
package dcache_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic int calc_off_w(int line_words);
    return $clog2(line_words) + 2;
  endfunction
  function automatic int calc_idx_w(int sets);
    return $clog2(sets);
  endfunction
  function automatic int calc_way_w(int ways);
    return ways > 1 ? $clog2(ways) : 1;
  endfunction
  function automatic logic [31:0] addr_index(logic [31:0] a, int off_w, int idx_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_word(logic [31:0] a, int off_w);
    return (a >> 2) & ((32'd1 << (off_w - 2)) - 32'd1);
  endfunction
endpackage

// File: rtl/dcache_data_way.sv
// dcache_data_way: one cache way, word-addressed RAM with byte-lane writes and read-first registered output
module dcache_data_way #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // byte-lane write; contents are deliberately not reset
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (we && be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  // registered read returns pre-write contents and holds while idle
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/dcache_data_array.sv
// dcache_data_array: N-way L1 data store with store-hit writes, bypass and a wrap-around refill sequencer
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 128,
  parameter int LINE_WORDS = 8,
  localparam int OFF_W = calc_off_w(LINE_WORDS),
  localparam int IDX_W = calc_idx_w(SETS),
  localparam int WAY_W = calc_way_w(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [31:0]          rd_addr,
  output logic                 rd_valid,
  output logic [32*WAYS-1:0]   rd_data,
  input  logic                 wr_en,
  input  logic [WAY_W-1:0]     wr_way,
  input  logic [31:0]          wr_addr,
  input  logic [3:0]           wr_be,
  input  logic [31:0]          wr_data,
  output logic                 wr_stall,
  input  logic                 refill_start,
  input  logic [WAY_W-1:0]     refill_way,
  input  logic [31:0]          refill_addr,
  input  logic                 refill_beat,
  input  logic [31:0]          refill_data,
  output logic                 refill_busy,
  output logic                 refill_done
);
  localparam int WD_W = OFF_W - 2;
  localparam int AW = IDX_W + WD_W;
  logic [1:0] state;
  logic [WAY_W-1:0] fill_way;
  logic [IDX_W-1:0] fill_idx;
  logic [WD_W-1:0] fill_start, fill_cnt;
  logic [AW-1:0] raddr, st_addr, beat_addr;
  logic beat_we, store_we;
  assign raddr = {IDX_W'(addr_index(rd_addr, OFF_W, IDX_W)), WD_W'(addr_word(rd_addr, OFF_W))};
  assign st_addr = {IDX_W'(addr_index(wr_addr, OFF_W, IDX_W)), WD_W'(addr_word(wr_addr, OFF_W))};
  assign beat_addr = {fill_idx, fill_start + fill_cnt};
  assign beat_we = state == S_FILL && refill_beat;
  assign wr_stall = wr_en && beat_we && wr_way == fill_way;
  assign store_we = wr_en && !wr_stall && |wr_be;
  assign refill_busy = state == S_FILL;
  assign refill_done = state == S_DONE;
  // read valid tracks rd_en with one cycle of latency
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_valid <= 1'b0;
    else rd_valid <= rd_en;
  // refill sequencer: latch line on start, count beats, one-cycle done state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      fill_way <= '0;
      fill_idx <= '0;
      fill_start <= '0;
      fill_cnt <= '0;
    end else if (state == S_IDLE && refill_start) begin
      state <= S_FILL;
      fill_way <= refill_way;
      fill_idx <= IDX_W'(addr_index(refill_addr, OFF_W, IDX_W));
      fill_start <= WD_W'(addr_word(refill_addr, OFF_W));
      fill_cnt <= '0;
    end else if (beat_we) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (&fill_cnt) state <= S_DONE;
    end else if (state == S_DONE) state <= S_IDLE;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic beat_w, store_w, we;
    logic [3:0] be, byp_be;
    logic [AW-1:0] wa;
    logic [31:0] wd, q, byp_d;
    assign beat_w = beat_we && fill_way == WAY_W'(w);
    assign store_w = store_we && wr_way == WAY_W'(w);
    assign we = beat_w || store_w;
    assign be = beat_w ? 4'hF : wr_be;
    assign wa = beat_w ? beat_addr : st_addr;
    assign wd = beat_w ? refill_data : wr_data;
    dcache_data_way #(.DEPTH(SETS * LINE_WORDS)) u_way (
      .clk(clk), .rst(rst), .we(we), .be(be), .waddr(wa), .wdata(wd),
      .re(rd_en), .raddr(raddr), .rdata(q)
    );
    // capture same-cycle write lanes so the read returns the new bytes
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        byp_be <= '0;
        byp_d <= '0;
      end else if (rd_en) begin
        byp_be <= we && wa == raddr ? be : 4'h0;
        byp_d <= wd;
      end
    for (genvar b = 0; b < 4; b++) begin : g_lane
      assign rd_data[32*w + 8*b +: 8] = byp_be[b] ? byp_d[8*b +: 8] : q[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_dcache_data_array.sv
// tb_dcache_data_array: scoreboard bench for the N-way data array and refill sequencer
module tb_dcache_data_array;
  localparam int WAYS = 2, SETS = 128, LW = 8, DEPTH = SETS * LW;
  logic clk = 0, rst = 1;
  logic rd_en, rd_valid, wr_en, wr_stall, refill_start, refill_beat, refill_busy, refill_done;
  logic [31:0] rd_addr, wr_addr, wr_data, refill_addr, refill_data;
  logic [63:0] rd_data;
  logic [0:0] wr_way, refill_way;
  logic [3:0] wr_be;
  logic [31:0] ref_mem [WAYS][DEPTH];
  logic [3:0] known [WAYS][DEPTH];
  int m_state = 0, m_way = 0, m_idx = 0, m_start = 0, m_cnt = 0, done_cnt = 0;
  logic [63:0] q_e[$], q_m[$];
  logic [63:0] last_e = 0, last_m = '1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dcache_data_array #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_stall(wr_stall),
    .refill_start(refill_start), .refill_way(refill_way), .refill_addr(refill_addr),
    .refill_beat(refill_beat), .refill_data(refill_data), .refill_busy(refill_busy), .refill_done(refill_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int flat(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic clear();
    rd_en = 0; rd_addr = 0; wr_en = 0; wr_way = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
    refill_start = 0; refill_way = 0; refill_addr = 0; refill_beat = 0; refill_data = 0;
  endtask

  task automatic step();
    logic bw, st, rdv;
    logic [63:0] e, m;
    int f;
    #1;
    bw = m_state == 1 && refill_beat;
    st = wr_en && bw && wr_way == m_way[0];
    chk("wr_stall", 64'(wr_stall), 64'(st));
    if (bw) begin
      f = m_idx * LW + (m_start + m_cnt) % LW;
      ref_mem[m_way][f] = refill_data;
      known[m_way][f] = 4'hF;
    end
    if (wr_en && !st) begin
      f = flat(wr_addr);
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) begin
          ref_mem[wr_way][f][8*b +: 8] = wr_data[8*b +: 8];
          known[wr_way][f][b] = 1'b1;
        end
    end
    if (rd_en) begin
      f = flat(rd_addr);
      for (int w = 0; w < WAYS; w++) begin
        e[32*w +: 32] = ref_mem[w][f];
        for (int b = 0; b < 4; b++) m[32*w + 8*b +: 8] = {8{known[w][f][b] === 1'b1}};
      end
      q_e.push_back(e);
      q_m.push_back(m);
    end
    if (m_state == 0 && refill_start) begin
      m_state = 1; m_way = int'(refill_way); m_cnt = 0;
      m_idx = int'((refill_addr >> 5) % SETS);
      m_start = int'((refill_addr >> 2) % LW);
    end else if (bw) begin
      m_cnt++;
      if (m_cnt == LW) m_state = 2;
    end else if (m_state == 2) m_state = 0;
    rdv = rd_en;
    @(posedge clk);
    @(negedge clk);
    chk("rd_valid", 64'(rd_valid), 64'(rdv));
    if (rdv) begin
      last_e = q_e.pop_front();
      last_m = q_m.pop_front();
    end
    chk("rd_data", rd_data & last_m, last_e & last_m);
    chk("refill_busy", 64'(refill_busy), 64'(m_state == 1));
    chk("refill_done", 64'(refill_done), 64'(m_state == 2));
    if (refill_done) done_cnt++;
  endtask

  task automatic wr(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    clear(); wr_en = 1; wr_way = w; wr_addr = a; wr_be = be; wr_data = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    clear(); rd_en = 1; rd_addr = a;
    step();
  endtask

  initial begin
    for (int w = 0; w < WAYS; w++)
      for (int i = 0; i < DEPTH; i++) known[w][i] = 4'h0;
    clear();
    @(negedge clk);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_busy", 64'(refill_busy), 64'd0);
    chk("reset_done", 64'(refill_done), 64'd0);
    rst = 0;
    // byte-enabled store over a known word
    wr(1, 32'h124, 4'hF, 32'h11223344);
    wr(1, 32'h124, 4'h5, 32'hAABBCCDD);
    rd(32'h124);
    chk("t1_word", 64'(rd_data[63:32]), 64'h11BB33DD);
    clear(); step();
    // critical-word-first refill, reading the beat word in the same cycle
    clear(); refill_start = 1; refill_way = 0; refill_addr = 32'h38; step();
    for (int i = 0; i < 8; i++) begin
      clear(); refill_beat = 1; refill_data = 32'h100 + i;
      rd_en = 1; rd_addr = 32'h20 | (((6 + i) % 8) << 2);
      step();
      chk("t2_bypass", 64'(rd_data[31:0]), 64'(32'h100 + i));
    end
    clear(); step();
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < 8; i++) begin
      rd(32'h20 | (((6 + i) % 8) << 2));
      chk("t2_word", 64'(rd_data[31:0]), 64'(32'h100 + i));
    end
    // gapped refill with ignored restarts and store conflicts
    wr(1, 32'h200, 4'hF, 32'h00001234);
    done_cnt = 0;
    clear(); refill_start = 1; refill_way = 1; refill_addr = 32'h44; step();
    for (int i = 0; i < 16; i++) begin
      clear(); refill_beat = (i % 2 == 0); refill_data = 32'h300 + i / 2;
      if (i == 3 || i == 15) begin refill_start = 1; refill_way = 0; refill_addr = 32'h80; end
      if (i == 4) begin wr_en = 1; wr_way = 1; wr_addr = 32'h200; wr_be = 4'hF; wr_data = 32'h5555; #1 chk("t4_stall", 64'(wr_stall), 64'd1); end
      if (i == 6) begin wr_en = 1; wr_way = 0; wr_addr = 32'h200; wr_be = 4'hF; wr_data = 32'h7777; #1 chk("t4_nostall", 64'(wr_stall), 64'd0); end
      step();
    end
    clear(); step();
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    rd(32'h200);
    chk("t4_store", rd_data, 64'h00001234_00007777);
    for (int i = 0; i < 8; i++) begin
      rd(32'h40 | (((1 + i) % 8) << 2));
      chk("t3_word", 64'(rd_data[63:32]), 64'(32'h300 + i));
    end
    // same-cycle write/read bypass
    wr(0, 32'h304, 4'hF, 32'h01020304);
    clear(); wr_en = 1; wr_addr = 32'h300; wr_be = 4'hF; wr_data = 32'hDEADBEEF; rd_en = 1; rd_addr = 32'h300; step();
    chk("t5_full", 64'(rd_data[31:0]), 64'hDEADBEEF);
    clear(); wr_en = 1; wr_addr = 32'h304; wr_be = 4'h1; wr_data = 32'hDEADBEEF; rd_en = 1; rd_addr = 32'h304; step();
    chk("t5_lane", 64'(rd_data[31:0]), 64'h010203EF);
    wr(0, 32'h304, 4'h0, 32'hFFFFFFFF);
    rd(32'h304);
    chk("t5_be0", 64'(rd_data[31:0]), 64'h010203EF);
    // reset mid-fill, with a read in flight
    done_cnt = 0;
    clear(); refill_start = 1; refill_way = 0; refill_addr = 32'h20; step();
    for (int i = 0; i < 3; i++) begin
      clear(); refill_beat = 1; refill_data = 32'h600 + i; step();
    end
    clear(); rd_en = 1; rd_addr = 32'h20;
    #2 rst = 1;
    #1;
    chk("t6_busy", 64'(refill_busy), 64'd0);
    chk("t6_done", 64'(refill_done), 64'd0);
    chk("t6_rd_valid", 64'(rd_valid), 64'd0);
    chk("t6_rd_data", rd_data, 64'd0);
    m_state = 0; m_cnt = 0; q_e.delete(); q_m.delete(); last_e = 0; last_m = '1;
    @(negedge clk);
    rst = 0;
    clear(); step();
    clear(); refill_beat = 1; refill_data = 32'hBAD; step();
    for (int i = 0; i < 8; i++) rd(32'h20 | (i << 2));
    for (int i = 0; i < 4; i++) begin
      rd(32'h20 | (i << 2));
      chk("t6_word", 64'(rd_data[31:0]), i < 3 ? 64'(32'h600 + i) : 64'h105);
    end
    chk("t6_done_cnt", 64'(done_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dcache_data_array.md
Name: dcache_data_array

Overview:
Parametrised N-way data store for the L1 data cache. It supersedes the single-way, fixed-geometry data RAM wrapper.
- Reads all ways of the addressed word in parallel, with fixed 1-cycle latency. Way selection by tag compare happens outside this block.
- Accepts byte-enabled store-hit writes.
- Runs its own line-refill sequencer: writes AXI refill beats critical-word-first, with wrap-around.
- Forwards same-cycle write data to reads.

Parameters:
WAYS, 2, number of ways (power of 2, ≥1)
SETS, 128, sets per way (power of 2)
LINE_WORDS, 8, 32-bit words per line (power of 2, ≥2)
Derived: OFF_W = log2(LINE_WORDS)+2; IDX_W = log2(SETS); WAY_W = max(1, log2(WAYS))

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rd_en  in  1  read request
rd_addr  in  32  byte address; index = [OFF_W+IDX_W-1:OFF_W], word = [OFF_W-1:2]
rd_valid  out  1  rd_data valid (rd_en delayed 1 cycle)
rd_data  out  32*WAYS  way w occupies bits [32w+31:32w]
wr_en  in  1  store-hit write
wr_way  in  WAY_W  target way
wr_addr  in  32  byte address
wr_be  in  4  byte enables
wr_data  in  32  store data
wr_stall  out  1  combinational; wr_en blocked this cycle, store unit must hold and retry
refill_start  in  1  begin line fill (accepted only when idle)
refill_way  in  WAY_W  victim way
refill_addr  in  32  miss address; its word offset is the first beat
refill_beat  in  1  refill_data valid this cycle
refill_data  in  32  beat data
refill_busy  out  1  sequencer in FILL
refill_done  out  1  1-cycle pulse after last beat is written

Behaviour:
- Reset values:
  - Outputs: rd_valid=0, rd_data=0, refill_busy=0, refill_done=0.
  - State: FSM=IDLE, beat counter=0.
  - RAM contents are not reset.
- Read: rd_en at edge t → rd_data/rd_valid at edge t+1. rd_data holds its last value while rd_en=0.
- Write port arbitration, one write per cycle per way. Priority order:
  - refill beat, then wr_en.
  - wr_stall=1 iff wr_en & FSM=FILL & refill_beat & wr_way==latched refill way. Otherwise wr_en commits at the edge; only lanes with wr_be set are written.
  - wr_en with wr_be=0: no effect.
- Bypass: a read and a committed write to the same way/set/word in the same cycle return the new bytes for enabled lanes and old bytes otherwise. A refill beat bypasses all 4 lanes.
- FSM:
  - IDLE: on refill_start, latch way, index and start word (refill_addr[OFF_W-1:2]); clear count; go to FILL; refill_busy=1 from the next cycle.
  - FILL: each refill_beat writes word (start+count) mod LINE_WORDS, then increments count. The beat with count==LINE_WORDS-1 moves to DONE.
  - DONE: refill_done=1 for one cycle; refill_busy=0; back to IDLE.
- Boundaries:
  - refill_start while FILL/DONE: ignored.
  - refill_beat in IDLE: ignored, no write.
  - Word index wraps at LINE_WORDS (e.g. start 6, LINE_WORDS 8: order 6,7,0,…,5).
  - Reads to the line being filled are permitted and return current RAM contents. Hit/miss gating is the controller's job.
  - rst asserted mid-FILL: immediate return to IDLE, no refill_done. Beats already written remain in RAM.
  - rst during rd_en: rd_valid=0 after release until a new rd_en.

Decomposition:
- Shared package (dcache_pkg): OFF_W, IDX_W, WAY_W derivation functions; FSM state encoding (IDLE, FILL, DONE); field-slice helpers for index and word.
- Sub-module dcache_data_way: one way, SETS*LINE_WORDS x 32 RAM, 4-lane byte write enable, synchronous read-first port, inferable as BRAM.
- Top: instantiates WAYS copies and contains arbitration, bypass and the refill FSM.

Test Plan:
1. Reset, then write way1 addr 0x0000_0124, be=4'b0101, data 0xAABBCCDD over prior 0x11223344; read next cycle → way1 word = 0x11BB33DD, rd_valid=1 exactly one cycle after rd_en.
2. Refill way0, refill_addr=0x0000_0038 (word 6), 8 beats 0x100..0x107 → RAM words 6,7,0..5 = 0x100..0x107; refill_done pulses one cycle after 8th beat; refill_busy high for 8 beat-cycles plus gaps.
3. Refill with gaps (refill_beat toggled 1,0,1), plus a second refill_start mid-fill → ignored; exactly 8 beats written; done once.
4. During FILL, wr_en to refill way with beat present → wr_stall=1, no store. Same to the other way → wr_stall=0, store committed.
5. Same-cycle write 0xDEADBEEF be=4'hF and read of the same word → rd_data shows 0xDEADBEEF next cycle; with be=4'h1 → old upper bytes, 0xEF low.
6. Assert rst after beat 3 → FSM IDLE, refill_done never pulses, words 0..2 of fill retain beat data, refill_beat in IDLE causes no write.
